nn_inference_sequencer: RTL

//  Sequences one neural-network inference per received serial frame.
//  - Synchronises the external serial clock and counts frame bits.
//  - On a complete frame: resets the NN, then holds NNvalid until maxValid.
//  - Latches the classification, flags timeout/overrun errors, counts inferences.
//  - Sits between the input shift register / NeuralNetwork pair and the display logic.

---
 rtl/nn_ctrl_pkg.sv | 22 ++
 rtl/nn_inference_sequencer_if.sv | 21 ++
 rtl/nn_inference_sequencer_sync_edge_detect.sv | 24 ++
 rtl/nn_inference_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared types and helpers for the NN inference sequencer.
// The state encoding and frame sizing are kept here so the top and its bench agree.
package nn_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RX       = 3'd1,
      ST_RESET_NN = 3'd2,
      ST_START    = 3'd3,
      ST_WAIT     = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   localparam int DEF_IDX_WIDTH = 4;
   localparam int DEF_VAL_WIDTH = 16;

   // Serial bits in one frame: every pixel is shifted in MSB-first, DATA_WIDTH bits each.
   function automatic int frame_bits(input int num_inputs, input int data_width);
      return num_inputs * data_width;
   endfunction

endpackage

// File: rtl/nn_inference_sequencer_if.sv
// Handshake between the sequencer (master) and the NeuralNetwork block (slave).
interface nn_inference_sequencer_if #(
   parameter int IDX_WIDTH = 4,
   parameter int VAL_WIDTH = 16
);
   logic                 nn_reset;
   logic                 nn_valid;
   logic                 nn_max_valid;
   logic [IDX_WIDTH-1:0] nn_max_index;
   logic [VAL_WIDTH-1:0] nn_max_value;

   modport master (
      output nn_reset, nn_valid,
      input  nn_max_valid, nn_max_index, nn_max_value
   );

   modport slave (
      input  nn_reset, nn_valid,
      output nn_max_valid, nn_max_index, nn_max_value
   );
endinterface

// File: rtl/nn_inference_sequencer_sync_edge_detect.sv
// Two-flop synchroniser plus registered rising-edge pulse for an asynchronous pin.
// The pulse appears three clk cycles after the pin rises.
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic edge_o
);
   logic [2:0] sync_q;
   logic       edge_q;

   // NOTE: non-blocking assignments keep each flop sampling the previous-cycle value of its neighbour.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], async_i};
         edge_q <= sync_q[1] & ~sync_q[2];
      end
   end

   assign edge_o = edge_q;
endmodule

// File: rtl/nn_inference_sequencer.sv
// Runs one NeuralNetwork inference per received serial frame (or soft_start),
// latches the argmax result and tracks timeout/overrun errors.
module nn_inference_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter int NUM_INPUTS     = 784,
   parameter int DATA_WIDTH     = 16,
   parameter int RESET_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int GAP_CYCLES     = 65536,
   parameter int IDX_WIDTH      = DEF_IDX_WIDTH,
   parameter int VAL_WIDTH      = DEF_VAL_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    serial_clk,
   input  logic                    soft_start,
   input  logic                    clear_err,
   nn_inference_sequencer_if.master nn_bus,
   output logic [IDX_WIDTH-1:0]    result_index,
   output logic [VAL_WIDTH-1:0]    result_value,
   output logic                    result_valid,
   output logic                    busy,
   output logic                    timeout_err,
   output logic                    overrun_err,
   output logic [7:0]              infer_count
);
   localparam int FRAME_BITS = frame_bits(NUM_INPUTS, DATA_WIDTH);
   localparam int BCW = $clog2(FRAME_BITS + 1);
   localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RCW = $clog2(RESET_CYCLES + 1);

   state_t               state_q;
   logic [BCW-1:0]       bit_cnt_q;
   logic [GCW-1:0]       gap_q;
   logic [WCW-1:0]       wd_q;
   logic [RCW-1:0]       rst_cnt_q;
   logic                 abort_q;
   logic                 nn_reset_q, nn_valid_q, busy_q;
   logic                 result_valid_q, timeout_err_q, overrun_err_q;
   logic [IDX_WIDTH-1:0] result_index_q;
   logic [VAL_WIDTH-1:0] result_value_q;
   logic [7:0]           infer_count_q;

   logic           rx_edge;
   logic [BCW-1:0] bit_cnt_inc, bit_cnt_sat;
   logic           frame_done, start_req;

   sync_edge_detect u_serial_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (serial_clk),
      .edge_o  (rx_edge)
   );

   assign bit_cnt_inc = bit_cnt_q + BCW'(1);
   assign frame_done  = (bit_cnt_inc == BCW'(FRAME_BITS));
   // Edges arriving while busy never complete a frame on their own; they wait for IDLE.
   assign bit_cnt_sat = frame_done ? bit_cnt_q : bit_cnt_inc;
   assign start_req   = soft_start || (rx_edge && frame_done);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= '0;
         gap_q          <= '0;
         wd_q           <= '0;
         rst_cnt_q      <= '0;
         abort_q        <= 1'b0;
         nn_reset_q     <= 1'b0;
         nn_valid_q     <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         overrun_err_q  <= 1'b0;
         result_index_q <= '0;
         result_value_q <= '0;
         infer_count_q  <= '0;
      end else begin
         result_valid_q <= 1'b0;
         // NOTE: a later non-blocking assignment in this block overrides this clear, so a new error wins.
         if (clear_err) begin
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE, ST_RX: begin
               if (start_req) begin
                  state_q    <= ST_RESET_NN;
                  nn_reset_q <= 1'b1;
                  rst_cnt_q  <= '0;
                  busy_q     <= 1'b1;
                  bit_cnt_q  <= (state_q == ST_IDLE && soft_start && rx_edge) ? bit_cnt_sat : '0;
               end else if (rx_edge) begin
                  state_q   <= ST_RX;
                  bit_cnt_q <= bit_cnt_inc;
                  gap_q     <= '0;
               end else if (state_q == ST_RX) begin
                  if (gap_q == GCW'(GAP_CYCLES - 1)) begin
                     state_q   <= ST_IDLE;
                     bit_cnt_q <= '0;
                     gap_q     <= '0;
                  end else begin
                     gap_q <= gap_q + GCW'(1);
                  end
               end
            end
            ST_RESET_NN: begin
               if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) begin
                  nn_reset_q <= 1'b0;
                  if (abort_q) begin
                     state_q <= ST_IDLE;
                     abort_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q    <= ST_START;
                     nn_valid_q <= 1'b1;
                  end
               end else begin
                  rst_cnt_q <= rst_cnt_q + RCW'(1);
               end
            end
            ST_START: begin
               state_q <= ST_WAIT;
               wd_q    <= '0;
            end
            ST_WAIT: begin
               if (nn_bus.nn_max_valid) begin
                  state_q        <= ST_DONE;
                  nn_valid_q     <= 1'b0;
                  busy_q         <= 1'b0;
                  result_index_q <= nn_bus.nn_max_index;
                  result_value_q <= nn_bus.nn_max_value;
                  result_valid_q <= 1'b1;
                  infer_count_q  <= infer_count_q + 8'd1;
               end else if (wd_q == WCW'(TIMEOUT_CYCLES - 1)) begin
                  // Flush the network once, then return to IDLE without restarting it.
                  state_q       <= ST_RESET_NN;
                  nn_valid_q    <= 1'b0;
                  nn_reset_q    <= 1'b1;
                  rst_cnt_q     <= '0;
                  abort_q       <= 1'b1;
                  timeout_err_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + WCW'(1);
               end
            end
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase

         if (rx_edge && (busy_q || state_q == ST_DONE)) begin
            overrun_err_q <= 1'b1;
            bit_cnt_q     <= bit_cnt_sat;
         end
      end
   end

   assign nn_bus.nn_reset = nn_reset_q;
   assign nn_bus.nn_valid = nn_valid_q;
   assign result_index    = result_index_q;
   assign result_value    = result_value_q;
   assign result_valid    = result_valid_q;
   assign busy            = busy_q;
   assign timeout_err     = timeout_err_q;
   assign overrun_err     = overrun_err_q;
   assign infer_count     = infer_count_q;
endmodule
